wb_sequencer: RTL and testbench
===============================

// Module: wb_sequencer
// PURPOSE
//  Controls the register-file writeback path of the MonoCycle core. It drives the writeback mux
//  select (MUXopRUW: 00 ALU, 01 data memory, 10 PC+4) and the register-file write enable.
//  It stalls the PC while a data-memory read is pending under a req/ack handshake, with a timeout.
//  It also flags illegal select codes, which the writeback mux itself does not decode.
// PARAMETERS
//  TIMEOUT   16   max cycles in MEM_WAIT without mem_ack before error (>=2)
//  RD_W      5    register-file address width
// PORTS
//  clk          in   1     core clock, all state on rising edge
//  rst          in   1     asynchronous, active-high reset
//  instr_valid  in   1     decoded instruction valid this cycle
//  wb_src       in   2     requested writeback source (00 ALU, 01 MEM, 10 PC+4, 11 illegal)
//  reg_write_in in   1     instruction writes a register
//  rd_in        in   RD_W  destination register
//  mem_ack      in   1     data-memory read data valid
//  err_clr      in   1     clears wb_err, returns to IDLE
//  MUXopRUW     out  2     writeback mux select (registered)
//  ru_we        out  1     register-file write enable (registered, 1-cycle pulse)
//  rd_out       out  RD_W  write address accompanying ru_we (registered)
//  mem_req      out  1     data-memory read request (registered, held in MEM_WAIT)
//  stall        out  1     hold PC / decode (combinational)
//  wb_err       out  1     memory timeout, sticky until err_clr
//  illegal_src  out  1     1-cycle pulse: instr_valid & reg_write_in & wb_src==11
// BEHAVIOUR
//  Reset: state=IDLE; MUXopRUW=00, ru_we=0, rd_out=0, mem_req=0, wb_err=0, illegal_src=0; timer=0.
//  Accept condition: instr_valid & reg_write_in in IDLE or WRITE. instr_valid with reg_write_in=0 is ignored.
//  States:
//   IDLE/WRITE (WRITE = 1-cycle memory writeback; it accepts new instructions exactly like IDLE):
//    - src 00/10: next cycle ru_we=1, MUXopRUW=src, rd_out=rd_in; latency 1; stall=0; next state IDLE.
//    - src 01: stall=1 combinationally this cycle; next state MEM_WAIT, mem_req=1, timer=0.
//    - src 11: no write; illegal_src=1 next cycle; state IDLE.
//   MEM_WAIT: stall=1, mem_req=1, timer++ each cycle.
//    - mem_ack: next state WRITE; in WRITE, ru_we=1, MUXopRUW=01, rd_out=latched rd, mem_req=0, stall=0.
//    - timer==TIMEOUT-1 without ack: next state ERR.
//    - ack in the same cycle as the timeout: ack wins.
//   ERR: wb_err=1, stall=1, mem_req=0, ru_we=0. err_clr -> IDLE with wb_err=0.
//  ru_we is forced to 0 when the target rd is 0 (x0); MUXopRUW and rd_out still update.
//  ru_we is 0 in every cycle not listed above. MUXopRUW holds its last value when ru_we=0.
//  mem_ack outside MEM_WAIT is ignored (no write, no state change).
//  rd is latched on acceptance; rd_in changes during MEM_WAIT have no effect.
//  Reset asserted mid-MEM_WAIT: immediate return to the reset values; the pending write is dropped.
//  err_clr outside ERR: no effect.
// TESTING
//  1 ALU: instr_valid, src=00, rd=5 at cycle 0 -> cycle 1: ru_we=1, MUXopRUW=00, rd_out=5; stall never 1.
//  2 Load: src=01, rd=7; mem_ack at cycle 3 -> stall 1 in cycles 0-3, mem_req 1 in cycles 1-3;
//    cycle 4: ru_we=1, MUXopRUW=01, rd_out=7, stall=0.
//  3 Back-to-back: load acked at cycle 2, ALU instr (rd=9) in cycle 3 (WRITE)
//    -> cycle 3: ru_we for the load; cycle 4: ru_we, MUXopRUW=00, rd_out=9.
//  4 Timeout with TIMEOUT=4, no ack -> ERR after 4 MEM_WAIT cycles: wb_err=1, stall=1, mem_req=0;
//    err_clr -> IDLE, wb_err=0. Second run with ack on the last wait cycle -> WRITE, not ERR.
//  5 Corner cases: src=11 -> illegal_src pulse, ru_we=0. src=00 with rd=0 -> ru_we=0.
//    Spurious mem_ack in IDLE -> no outputs change.
//  6 Reset mid-MEM_WAIT (rst at cycle 2 of a load) -> all outputs at reset values immediately; no write after release.

Source files
------------

// File: rtl/wb_sequencer.sv
// wb_sequencer: register-file writeback sequencer with load stall, memory timeout and illegal-source flag
module wb_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int RD_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [1:0]      wb_src,
    input  logic            reg_write_in,
    input  logic [RD_W-1:0] rd_in,
    input  logic            mem_ack,
    input  logic            err_clr,
    output logic [1:0]      MUXopRUW,
    output logic            ru_we,
    output logic [RD_W-1:0] rd_out,
    output logic            mem_req,
    output logic            stall,
    output logic            wb_err,
    output logic            illegal_src
);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, MEM_WAIT, WRITE, ERR} state_t;
    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [RD_W-1:0] rd_lat_q, rd_lat_d, rd_out_q, rd_out_d;
    logic [1:0]      mux_q, mux_d;
    logic            we_q, we_d, req_q, err_q, ill_q, ill_d;
    logic            accept;
    assign accept      = instr_valid & reg_write_in;
    assign MUXopRUW    = mux_q;
    assign ru_we       = we_q;
    assign rd_out      = rd_out_q;
    assign mem_req     = req_q;
    assign wb_err      = err_q;
    assign illegal_src = ill_q;
    // Next state, next outputs and the combinational stall; a write to x0 keeps the enable low
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        rd_lat_d = rd_lat_q;
        rd_out_d = rd_out_q;
        mux_d    = mux_q;
        we_d     = 1'b0;
        ill_d    = 1'b0;
        stall    = 1'b0;
        case (state_q)
            MEM_WAIT: begin
                stall = 1'b1;
                if (mem_ack) begin
                    state_d  = WRITE;
                    we_d     = |rd_lat_q;
                    mux_d    = 2'b01;
                    rd_out_d = rd_lat_q;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ERR: begin
                stall = 1'b1;
                if (err_clr) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    if (wb_src == 2'b01) begin
                        state_d  = MEM_WAIT;
                        timer_d  = '0;
                        rd_lat_d = rd_in;
                        stall    = 1'b1;
                    end else if (wb_src == 2'b11) begin
                        ill_d = 1'b1;
                    end else begin
                        we_d     = |rd_in;
                        mux_d    = wb_src;
                        rd_out_d = rd_in;
                    end
                end
            end
        endcase
    end
    // State and registered outputs; mem_req and wb_err mirror the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            rd_lat_q <= '0;
            rd_out_q <= '0;
            mux_q    <= 2'b00;
            we_q     <= 1'b0;
            req_q    <= 1'b0;
            err_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            rd_lat_q <= rd_lat_d;
            rd_out_q <= rd_out_d;
            mux_q    <= mux_d;
            we_q     <= we_d;
            req_q    <= (state_d == MEM_WAIT);
            err_q    <= (state_d == ERR);
            ill_q    <= ill_d;
        end
    end
endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: scenario tasks with a write scoreboard for wb_sequencer
module tb_wb_sequencer;
    logic       clk = 1'b0, rst = 1'b1;
    logic       instr_valid = 1'b0, reg_write_in = 1'b0, mem_ack = 1'b0, err_clr = 1'b0;
    logic [1:0] wb_src = 2'b00;
    logic [4:0] rd_in = 5'd0;
    logic [1:0] MUXopRUW;
    logic [4:0] rd_out;
    logic       ru_we, mem_req, stall, wb_err, illegal_src;
    int         checks = 0, errors = 0;
    logic [6:0] exp_q[$];
    logic [6:0] mon_e;

    always #5 clk = ~clk;

    wb_sequencer #(.TIMEOUT(4), .RD_W(5)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .wb_src(wb_src),
        .reg_write_in(reg_write_in), .rd_in(rd_in), .mem_ack(mem_ack), .err_clr(err_clr),
        .MUXopRUW(MUXopRUW), .ru_we(ru_we), .rd_out(rd_out), .mem_req(mem_req),
        .stall(stall), .wb_err(wb_err), .illegal_src(illegal_src)
    );

    // every observed write must match the oldest expected {mux, rd}
    always @(negedge clk) begin
        if (!rst && ru_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got mux=%0d rd=%0d expected no write", MUXopRUW, rd_out);
            end else begin
                mon_e = exp_q.pop_front();
                if ({MUXopRUW, rd_out} !== mon_e) begin
                    errors++;
                    $display("FAIL wb_write got mux=%0d rd=%0d expected mux=%0d rd=%0d",
                             MUXopRUW, rd_out, mon_e[6:5], mon_e[4:0]);
                end
            end
        end
    end

    task automatic idle_in();
        instr_valid = 1'b0; reg_write_in = 1'b0; wb_src = 2'b00; rd_in = 5'd0;
        mem_ack = 1'b0; err_clr = 1'b0;
    endtask

    task automatic issue(input logic [1:0] src, input logic [4:0] rd);
        instr_valid = 1'b1; reg_write_in = 1'b1; wb_src = src; rd_in = rd;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({MUXopRUW, ru_we, rd_out, mem_req, wb_err, illegal_src, stall} !== 12'd0) begin
            errors++;
            $display("FAIL reset got %b expected all zero",
                     {MUXopRUW, ru_we, rd_out, mem_req, wb_err, illegal_src, stall});
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        @(negedge clk);
        issue(2'b00, 5'd5);
        exp_q.push_back({2'b00, 5'd5});
        #1 checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall0 got %b expected 0", stall); end
        @(negedge clk);
        checks++;
        if ({ru_we, MUXopRUW, rd_out} !== {1'b1, 2'b00, 5'd5}) begin
            errors++; $display("FAIL alu_write got we=%b mux=%0d rd=%0d expected 1/0/5", ru_we, MUXopRUW, rd_out);
        end
        idle_in();
        #1 checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall1 got %b expected 0", stall); end
        @(negedge clk);
        checks++;
        if (ru_we !== 1'b0) begin errors++; $display("FAIL alu_pulse got %b expected 0", ru_we); end
    endtask

    task automatic test_load();
        @(negedge clk);
        issue(2'b01, 5'd7);
        #1 checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL load_stall_c0 got %b expected 1", stall); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            issue(2'b00, 5'd3);
            if (c == 3) begin
                mem_ack = 1'b1;
                exp_q.push_back({2'b01, 5'd7});
            end
            #1 checks++;
            if ({stall, mem_req, ru_we} !== 3'b110) begin
                errors++; $display("FAIL load_wait c%0d got stall/req/we=%b expected 110", c, {stall, mem_req, ru_we});
            end
        end
        @(negedge clk);
        idle_in();
        #1 checks++;
        if ({ru_we, MUXopRUW, rd_out, stall, mem_req} !== {1'b1, 2'b01, 5'd7, 1'b0, 1'b0}) begin
            errors++; $display("FAIL load_write got we=%b mux=%0d rd=%0d stall=%b req=%b expected 1/1/7/0/0",
                               ru_we, MUXopRUW, rd_out, stall, mem_req);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(2'b01, 5'd10);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        mem_ack = 1'b1;
        exp_q.push_back({2'b01, 5'd10});
        @(negedge clk);
        mem_ack = 1'b0;
        issue(2'b00, 5'd9);
        exp_q.push_back({2'b00, 5'd9});
        #1 checks++;
        if ({ru_we, MUXopRUW, rd_out, stall} !== {1'b1, 2'b01, 5'd10, 1'b0}) begin
            errors++; $display("FAIL b2b_load got we=%b mux=%0d rd=%0d stall=%b expected 1/1/10/0",
                               ru_we, MUXopRUW, rd_out, stall);
        end
        @(negedge clk);
        idle_in();
        checks++;
        if ({ru_we, MUXopRUW, rd_out} !== {1'b1, 2'b00, 5'd9}) begin
            errors++; $display("FAIL b2b_alu got we=%b mux=%0d rd=%0d expected 1/0/9", ru_we, MUXopRUW, rd_out);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        issue(2'b01, 5'd4);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            idle_in();
            checks++;
            if ({mem_req, wb_err} !== 2'b10) begin
                errors++; $display("FAIL to_wait c%0d got req/err=%b expected 10", c, {mem_req, wb_err});
            end
        end
        for (int c = 5; c <= 6; c++) begin
            @(negedge clk);
            err_clr = (c == 6);
            #1 checks++;
            if ({wb_err, stall, mem_req, ru_we} !== 4'b1100) begin
                errors++; $display("FAIL to_err c%0d got err/stall/req/we=%b expected 1100", c, {wb_err, stall, mem_req, ru_we});
            end
        end
        @(negedge clk);
        idle_in();
        #1 checks++;
        if ({wb_err, stall} !== 2'b00) begin
            errors++; $display("FAIL to_clear got err/stall=%b expected 00", {wb_err, stall});
        end
        issue(2'b01, 5'd6);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            idle_in();
            if (c == 4) begin
                mem_ack = 1'b1;
                exp_q.push_back({2'b01, 5'd6});
            end
        end
        @(negedge clk);
        idle_in();
        #1 checks++;
        if ({ru_we, wb_err, stall, MUXopRUW, rd_out} !== {1'b1, 1'b0, 1'b0, 2'b01, 5'd6}) begin
            errors++; $display("FAIL to_lastack got we=%b err=%b stall=%b mux=%0d rd=%0d expected 1/0/0/1/6",
                               ru_we, wb_err, stall, MUXopRUW, rd_out);
        end
    endtask

    task automatic test_corner();
        @(negedge clk);
        issue(2'b11, 5'd12);
        @(negedge clk);
        idle_in();
        checks++;
        if ({illegal_src, ru_we, MUXopRUW, rd_out} !== {1'b1, 1'b0, 2'b01, 5'd6}) begin
            errors++; $display("FAIL illegal got ill=%b we=%b mux=%0d rd=%0d expected 1/0/1/6",
                               illegal_src, ru_we, MUXopRUW, rd_out);
        end
        issue(2'b00, 5'd0);
        @(negedge clk);
        idle_in();
        checks++;
        if ({illegal_src, ru_we, MUXopRUW, rd_out} !== {1'b0, 1'b0, 2'b00, 5'd0}) begin
            errors++; $display("FAIL rd_zero got ill=%b we=%b mux=%0d rd=%0d expected 0/0/0/0",
                               illegal_src, ru_we, MUXopRUW, rd_out);
        end
        instr_valid = 1'b1; wb_src = 2'b10; rd_in = 5'd20;
        @(negedge clk);
        idle_in();
        mem_ack = 1'b1; err_clr = 1'b1;
        #1 checks++;
        if ({ru_we, MUXopRUW, rd_out, stall} !== {1'b0, 2'b00, 5'd0, 1'b0}) begin
            errors++; $display("FAIL no_regwrite got we=%b mux=%0d rd=%0d stall=%b expected 0/0/0/0",
                               ru_we, MUXopRUW, rd_out, stall);
        end
        @(negedge clk);
        idle_in();
        #1 checks++;
        if ({ru_we, MUXopRUW, rd_out, mem_req, wb_err, illegal_src, stall} !== 12'd0) begin
            errors++; $display("FAIL spurious_ack got %b expected all zero",
                               {ru_we, MUXopRUW, rd_out, mem_req, wb_err, illegal_src, stall});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        issue(2'b10, 5'd14);
        exp_q.push_back({2'b10, 5'd14});
        @(negedge clk);
        issue(2'b01, 5'd8);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        rst = 1'b1;
        #1 checks++;
        if ({MUXopRUW, ru_we, rd_out, mem_req, wb_err, illegal_src, stall} !== 12'd0) begin
            errors++; $display("FAIL rst_mid got %b expected all zero",
                               {MUXopRUW, ru_we, rd_out, mem_req, wb_err, illegal_src, stall});
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({ru_we, mem_req} !== 2'b00) begin
                errors++; $display("FAIL rst_after c%0d got we/req=%b expected 00", c, {ru_we, mem_req});
            end
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_back_to_back();
        test_timeout();
        test_corner();
        test_reset_mid();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_drain got %0d pending writes expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
